// File: rtl/reg_op_sequencer_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_op_sequencer_pkg: opcodes, FSM encoding and register-file geometry.
// Rev 1.0
// ----------------------------------------------------------------------------
package reg_op_sequencer_pkg;

  // Geometry shared with the 3-read/1-write register file
  localparam int DEF_M = 4;
  localparam int DEF_N = 15;
  localparam int DEF_W = 8;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MAC = 3'd5;
  localparam logic [2:0] OP_MAX = 3'd6;
  localparam logic [2:0] OP_LDI = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/reg_op_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_op_alu: combinational result unit; REG_OP_SEQUENCER_FLAGS_EN adds carry.
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_op_alu
  import reg_op_sequencer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] imm,
  output logic [W-1:0] result
`ifdef REG_OP_SEQUENCER_FLAGS_EN
  ,
  output logic         carry
`endif
);

  logic [W-1:0] add_res;

`ifdef REG_OP_SEQUENCER_FLAGS_EN
  logic [W:0] sum_ext;

  assign sum_ext = {1'b0, a} + {1'b0, b};
  assign add_res = sum_ext[W-1:0];
  // SUB reports a borrow rather than the raw carry-out
  assign carry   = (op == OP_ADD) ? sum_ext[W] :
                   (op == OP_SUB) ? (a < b)    : 1'b0;
`else
  assign add_res = a + b;
`endif

  always_comb begin
    result = '0;
    case (op)
      OP_ADD:  result = add_res;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MAC:  result = a * b + c;
      OP_MAX:  result = (a > b) ? a : b;
      default: result = imm;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_op_sequencer: read/exec/write controller around a 3R/1W register file.
// Optional: REG_OP_SEQUENCER_FLAGS_EN adds zero_flag/carry_flag.  Rev 1.0
// ----------------------------------------------------------------------------
module reg_op_sequencer
  import reg_op_sequencer_pkg::*;
#(
  parameter int M = DEF_M,
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   in_op,
  input  logic [M-1:0] in_rd,
  input  logic [M-1:0] in_rs1,
  input  logic [M-1:0] in_rs2,
  input  logic [M-1:0] in_rs3,
  input  logic [W-1:0] in_imm,
  output logic         ReadEn,
  output logic [M-1:0] ReadReg1,
  output logic [M-1:0] ReadReg2,
  output logic [M-1:0] ReadReg3,
  input  logic [W-1:0] ReadData1,
  input  logic [W-1:0] ReadData2,
  input  logic [W-1:0] ReadData3,
  output logic         WriteEn,
  output logic [M-1:0] WriteReg,
  output logic [W-1:0] WriteData,
  output logic         done,
  output logic         err
`ifdef REG_OP_SEQUENCER_FLAGS_EN
  ,
  output logic         zero_flag,
  output logic         carry_flag
`endif
);

  localparam logic [M:0] N_LIM = (M+1)'(N);

  state_t       state, state_nx;
  logic [2:0]   op_q;
  logic [M-1:0] rd_q, rs1_q, rs2_q, rs3_q;
  logic [W-1:0] imm_q;
  logic [W-1:0] result_q, alu_result;
  logic         illegal_q, illegal_nx;

  // LDI never uses its source operands, so they cannot make it illegal
  assign illegal_nx = ({1'b0, rd_q} >= N_LIM) ||
                      ((op_q != OP_LDI) && (({1'b0, rs1_q} >= N_LIM) ||
                                            ({1'b0, rs2_q} >= N_LIM) ||
                                            ({1'b0, rs3_q} >= N_LIM)));

`ifdef REG_OP_SEQUENCER_FLAGS_EN
  logic alu_carry, carry_q;

  reg_op_alu #(.W(W)) u_alu (
    .op     (op_q),
    .a      (ReadData1),
    .b      (ReadData2),
    .c      (ReadData3),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );
`else
  reg_op_alu #(.W(W)) u_alu (
    .op     (op_q),
    .a      (ReadData1),
    .b      (ReadData2),
    .c      (ReadData3),
    .imm    (imm_q),
    .result (alu_result)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    ReadEn    = 1'b0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    ReadReg3  = '0;
    WriteEn   = 1'b0;
    WriteReg  = '0;
    WriteData = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = ST_READ;
      end
      ST_READ: begin
        ReadEn   = 1'b1;
        ReadReg1 = rs1_q;
        ReadReg2 = rs2_q;
        ReadReg3 = rs3_q;
        state_nx = ST_EXEC;
      end
      ST_EXEC: state_nx = ST_WRITE;
      default: begin
        WriteEn   = !illegal_q;
        WriteReg  = rd_q;
        WriteData = result_q;
        done      = 1'b1;
        err       = illegal_q;
        state_nx  = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rs3_q     <= '0;
      imm_q     <= '0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid) begin
        op_q  <= in_op;
        rd_q  <= in_rd;
        rs1_q <= in_rs1;
        rs2_q <= in_rs2;
        rs3_q <= in_rs3;
        imm_q <= in_imm;
      end
      if (state == ST_EXEC) begin
        result_q  <= alu_result;
        illegal_q <= illegal_nx;
      end
    end
  end

`ifdef REG_OP_SEQUENCER_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      if (state == ST_EXEC) carry_q <= alu_carry;
      if (state == ST_WRITE && !illegal_q) begin
        zero_flag  <= (result_q == '0);
        carry_flag <= carry_q;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// tb_reg_op_sequencer: directed and random instructions against a behavioural
// model of the sequencer plus a bench-owned register file.
module tb_reg_op_sequencer;

  localparam int M = 4;
  localparam int N = 15;
  localparam int W = 8;
  localparam logic [7:0] RB [8] = '{8'h05, 8'h03, 8'h08, 8'hFE, 8'h00, 8'h10, 8'h01, 8'h01};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic in_valid = 1'b0;
  logic [2:0] in_op = '0;
  logic [3:0] in_rd = '0, in_rs1 = '0, in_rs2 = '0, in_rs3 = '0;
  logic [7:0] in_imm = '0;
  logic in_ready, ReadEn, WriteEn, done, err;
  logic [3:0] ReadReg1, ReadReg2, ReadReg3, WriteReg;
  logic [7:0] ReadData1 = '0, ReadData2 = '0, ReadData3 = '0, WriteData;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
  logic zero_flag, carry_flag;
`endif

  int checks = 0;
  int errors = 0;
  bit armed = 0;

  always #5 clk = ~clk;

  reg_op_sequencer #(.M(M), .N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rs3(in_rs3),
    .in_imm(in_imm), .ReadEn(ReadEn), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadReg3(ReadReg3), .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadData3(ReadData3), .WriteEn(WriteEn), .WriteReg(WriteReg),
    .WriteData(WriteData), .done(done), .err(err)
`ifdef REG_OP_SEQUENCER_FLAGS_EN
    , .zero_flag(zero_flag), .carry_flag(carry_flag)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- register file environment (1-cycle registered read) ----
  logic [7:0] seedv [16];
  logic [7:0] fmem [16];
  bit f_loaded = 0;

  always @(posedge clk) begin
    if (!f_loaded) begin
      for (int i = 0; i < 16; i++) fmem[i] <= seedv[i];
      f_loaded <= 1;
    end else if (WriteEn) begin
      fmem[WriteReg] <= WriteData;
    end
    if (ReadEn) begin
      ReadData1 <= fmem[ReadReg1];
      ReadData2 <= fmem[ReadReg2];
      ReadData3 <= fmem[ReadReg3];
    end
  end

  // ---------------- behavioural model ---------------------------------------
  function automatic void alu_model(input int op, input int a, input int b, input int c,
                                    input int imm, output int r, output bit cy);
    int s;
    cy = 0;
    case (op)
      0: begin s = a + b; cy = (s > 255); end
      1: begin s = a - b; cy = (a < b); end
      2: s = a & b;
      3: s = a | b;
      4: s = a ^ b;
      5: s = a * b + c;
      6: s = (a > b) ? a : b;
      default: s = imm;
    endcase
    r = s & 255;
  endfunction

  logic [7:0] mreg [16];
  bit m_loaded = 0;
  int m_cyc = 0, m_t = 0;
  bit m_pend = 0, m_err = 0, m_c = 0, m_chkdata = 0, m_zero = 0, m_carry = 0;
  int m_rd = 0, m_rs1 = 0, m_rs2 = 0, m_rs3 = 0, m_res = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend = 0; m_zero = 0; m_carry = 0;
      if (!m_loaded) begin
        for (int i = 0; i < 16; i++) mreg[i] = seedv[i];
        m_loaded = 1;
      end
    end else begin
      m_cyc++;
      if (m_pend && (m_cyc - m_t == 3)) begin
        if (!m_err) begin
          mreg[m_rd] = 8'(m_res);
          m_zero = (m_res == 0);
          m_carry = m_c;
        end
        m_pend = 0;
      end else if (!m_pend && in_valid) begin
        int r; bit cy;
        m_pend = 1; m_t = m_cyc;
        m_rd = in_rd; m_rs1 = in_rs1; m_rs2 = in_rs2; m_rs3 = in_rs3;
        alu_model(in_op, mreg[in_rs1], mreg[in_rs2], mreg[in_rs3], in_imm, r, cy);
        m_res = r; m_c = cy;
        m_chkdata = (in_op == 3'd7) || (m_rs1 < N && m_rs2 < N && m_rs3 < N);
        m_err = (m_rd >= N) || ((in_op != 3'd7) && !(m_rs1 < N && m_rs2 < N && m_rs3 < N));
      end
    end
  end

  // ---------------- per-cycle compare ----------------------------------------
  logic [7:0] wlog [$];
  bit last_err = 0;

  always @(negedge clk) begin
    if (armed) begin
      int d;
      bit e_done;
      d = m_cyc - m_t;
      e_done = m_pend && (d == 2);
      chk("in_ready", in_ready, !m_pend);
      chk("ReadEn", ReadEn, m_pend && (d == 0));
      chk("done", done, e_done);
      chk("WriteEn", WriteEn, e_done && !m_err);
      if (m_pend && d == 0) begin
        chk("ReadReg1", ReadReg1, m_rs1);
        chk("ReadReg2", ReadReg2, m_rs2);
        chk("ReadReg3", ReadReg3, m_rs3);
      end
      if (e_done) begin
        chk("WriteReg", WriteReg, m_rd);
        chk("err", err, m_err);
        if (m_chkdata) chk("WriteData", WriteData, m_res);
      end
`ifdef REG_OP_SEQUENCER_FLAGS_EN
      chk("zero_flag", zero_flag, m_zero);
      chk("carry_flag", carry_flag, m_carry);
`endif
      if (done) begin
        wlog.push_back(WriteData);
        last_err = err;
      end
    end
  end

  // ---------------- stimulus --------------------------------------------------
  // Called at posedge+2; returns at posedge+2 just after the accept edge.
  task automatic issue(input int op, input int rd, input int rs1, input int rs2,
                       input int rs3, input int imm);
    bit got = 0;
    bit rdy;
    in_op = 3'(op); in_rd = 4'(rd); in_rs1 = 4'(rs1); in_rs2 = 4'(rs2);
    in_rs3 = 4'(rs3); in_imm = 8'(imm); in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); if (rdy) got = 1;
    end
    #2;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk); if (done) got = 1;
    end
    @(posedge clk); #2;
    if (!got) chk("done_timeout", 0, 1);
  endtask

  task automatic run(input int op, input int rd, input int rs1, input int rs2,
                     input int rs3, input int imm);
    issue(op, rd, rs1, rs2, rs3, imm);
    in_valid = 1'b0;
    wait_done();
  endtask

  initial begin
    logic [7:0] saved;
    for (int i = 0; i < 16; i++) seedv[i] = 8'($urandom_range(0, 255));
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ReadEn", ReadEn, 0);
    chk("rst_WriteEn", WriteEn, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_WriteReg", WriteReg, 0);
    chk("rst_WriteData", WriteData, 0);
    chk("rst_ReadReg1", ReadReg1, 0);
    armed = 1;
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;

    run(7, 1, 0, 0, 0, 8'h05);
    run(7, 2, 0, 0, 0, 8'h03);
    run(0, 3, 1, 2, 0, 0);
    chk("add_r3_data", wlog[$], 8'h08);
    chk("add_r3_err", last_err, 0);
    run(1, 4, 2, 1, 0, 0);
    chk("sub_r4_data", wlog[$], 8'hFE);
`ifdef REG_OP_SEQUENCER_FLAGS_EN
    chk("sub_carry", carry_flag, 1);
    chk("sub_zero", zero_flag, 0);
`endif
    run(4, 5, 1, 1, 0, 0);
    chk("xor_r5_data", wlog[$], 8'h00);
`ifdef REG_OP_SEQUENCER_FLAGS_EN
    chk("xor_zero", zero_flag, 1);
`endif
    run(7, 6, 0, 0, 0, 8'h10);
    run(7, 7, 0, 0, 0, 8'h01);
    run(5, 8, 6, 6, 7, 0);
    chk("mac_r8_data", wlog[$], 8'h01);
    run(5, 9, 1, 2, 3, 0);
    chk("mac_r9_data", wlog[$], 8'h17);
    run(0, 15, 1, 2, 0, 0);
    chk("ill_rd_err", last_err, 1);
    run(0, 1, 1, 15, 0, 0);
    chk("ill_rs2_err", last_err, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("readback_r%0d", i + 1), fmem[i + 1], RB[i]);

    // in_valid held across two instructions: second must see the first's write
    issue(0, 1, 1, 1, 0, 0);
    issue(0, 1, 1, 1, 0, 0);
    in_valid = 1'b0;
    wait_done();
    chk("raw_first", wlog[$-1], 8'h0A);
    chk("raw_second", wlog[$], 8'h14);

    // reset during EXEC drops the instruction
    run(7, 10, 0, 0, 0, 8'h33);
    saved = fmem[10];
    chk("r10_pre", saved, 8'h33);
    issue(7, 10, 0, 0, 0, 8'h77);
    in_valid = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("rst_mid_ready", in_ready, 1);
    @(posedge clk); #2 rst_n = 1'b1;
    @(posedge clk); #2;
    chk("rst_mid_nowrite", fmem[10], 8'h33);
    run(7, 10, 0, 0, 0, 8'h42);
    chk("post_rst_ldi", fmem[10], 8'h42);

    for (int n = 0; n < 150; n++) begin
      run($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    for (int i = 0; i < N; i++) chk($sformatf("final_r%0d", i), fmem[i], mreg[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
